// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the vectored interrupt controller: register map,
// FSM encoding and default source count.
package int_ctrl_pkg;

    localparam int N_SRC_DEFAULT = 8;

    localparam logic [1:0] OFF_MASK = 2'd0;
    localparam logic [1:0] OFF_PEND = 2'd1;
    localparam logic [1:0] OFF_INSV = 2'd2;
    localparam logic [1:0] OFF_CTRL = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Lowest-index-first priority encoder; idx_o is meaningful only when valid_o=1.
module prio_enc #(
    parameter int N = 8,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o   = W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Eight-source vectored interrupt controller with edge-detected pending bits,
// priority nesting and a req/ack/ret handshake to the CPU control unit.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          N_SRC      = N_SRC_DEFAULT,
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter logic [7:0]  VEC_BASE   = 8'h10,
    parameter logic [7:0]  VEC_STRIDE = 8'h04
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             bus_we,
    input  logic [15:0]      bus_addr,
    input  logic [7:0]       bus_wdata,
    output logic [7:0]       bus_rdata,
    output logic             int_req,
    output logic [7:0]       int_vec,
    input  logic             int_ack,
    input  logic             int_ret
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic [7:0]         vec_q, vec_d;
    logic [N_SRC-1:0]   mask_q, mask_d, pend_q, pend_d, insv_q, insv_d, irq_prev_q;
    logic               gie_q, gie_d;

    logic [15:0]        off;
    logic               hit, wr_mask, wr_pend, wr_ctrl, ack_take;
    logic [N_SRC-1:0]   edges, below, elig;
    logic [IDX_W-1:0]   elig_idx, lvl_idx;
    logic               elig_vld, lvl_vld;

    assign off     = bus_addr - BASE_ADDR;
    assign hit     = (off[15:2] == 14'd0);
    assign wr_mask = bus_we && hit && (off[1:0] == OFF_MASK);
    assign wr_pend = bus_we && hit && (off[1:0] == OFF_PEND);
    assign wr_ctrl = bus_we && hit && (off[1:0] == OFF_CTRL);

    always_comb begin
        bus_rdata = 8'h00;
        if (hit) begin
            case (off[1:0])
                OFF_MASK: bus_rdata = 8'(mask_q);
                OFF_PEND: bus_rdata = 8'(pend_q);
                OFF_INSV: bus_rdata = 8'(insv_q);
                OFF_CTRL: bus_rdata = {7'd0, gie_q};
                default:  bus_rdata = 8'h00;
            endcase
        end
    end

    prio_enc #(.N(N_SRC), .W(IDX_W)) u_level (
        .req_i  (insv_q),
        .idx_o  (lvl_idx),
        .valid_o(lvl_vld)
    );

    // Only sources strictly above the current in-service level may nest.
    always_comb begin
        below = '0;
        for (int i = 0; i < N_SRC; i++) begin
            below[i] = !lvl_vld || (IDX_W'(i) < lvl_idx);
        end
    end

    assign elig = gie_q ? (pend_q & mask_q & below) : '0;

    prio_enc #(.N(N_SRC), .W(IDX_W)) u_elig (
        .req_i  (elig),
        .idx_o  (elig_idx),
        .valid_o(elig_vld)
    );

    assign ack_take = (state_q == ST_REQ) && int_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            vec_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            vec_q   <= vec_d;
        end
    end

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        vec_d   = vec_q;
        case (state_q)
            ST_IDLE: begin
                if (elig_vld) begin
                    state_d = ST_REQ;
                    id_d    = elig_idx;
                    vec_d   = VEC_BASE + 8'(elig_idx) * VEC_STRIDE;
                end
            end
            ST_REQ: begin
                if (int_ack || !elig[id_q]) begin
                    state_d = ST_IDLE;
                    vec_d   = 8'h00;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        int_req = (state_q == ST_REQ);
        int_vec = vec_q;
    end

    // Edge sets are applied last so a coincident clear loses to a new edge.
    always_comb begin
        edges  = irq_in & ~irq_prev_q;
        mask_d = wr_mask ? bus_wdata[N_SRC-1:0] : mask_q;
        gie_d  = wr_ctrl ? bus_wdata[0] : gie_q;
        pend_d = pend_q;
        if (wr_pend)  pend_d = pend_d & ~bus_wdata[N_SRC-1:0];
        if (ack_take) pend_d[id_q] = 1'b0;
        pend_d = pend_d | edges;
        insv_d = insv_q;
        if (int_ret && lvl_vld) insv_d[lvl_idx] = 1'b0;
        if (ack_take)           insv_d[id_q]    = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q     <= '0;
            pend_q     <= '0;
            insv_q     <= '0;
            gie_q      <= 1'b0;
            irq_prev_q <= '1;
        end else begin
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            insv_q     <= insv_d;
            gie_q      <= gie_d;
            irq_prev_q <= irq_in;
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus randomized traffic
// against a behavioural model of the controller.
module tb_int_ctrl;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_in;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        int_req;
    logic [7:0]  int_vec;
    logic        int_ack;
    logic        int_ret;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] m_mask, m_pend, m_insv, m_prev;
    logic       m_gie;
    bit         m_req;
    int         m_id;

    int_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .irq_in   (irq_in),
        .bus_we   (bus_we),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .int_req  (int_req),
        .int_vec  (int_vec),
        .int_ack  (int_ack),
        .int_ret  (int_ret)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] off, output logic [7:0] d);
        bus_addr = BASE + 16'(off);
        #1;
        d = bus_rdata;
    endtask

    task automatic wr(input logic [1:0] off, input logic [7:0] d);
        bus_addr  = BASE + 16'(off);
        bus_wdata = d;
        bus_we    = 1'b1;
        tick();
        bus_we    = 1'b0;
    endtask

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    function automatic logic [7:0] model_read(input logic [15:0] a);
        logic [15:0] off;
        off = a - BASE;
        if (off == 16'd0) return m_mask;
        if (off == 16'd1) return m_pend;
        if (off == 16'd2) return m_insv;
        if (off == 16'd3) return {7'd0, m_gie};
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_mask = 8'h00; m_pend = 8'h00; m_insv = 8'h00; m_gie = 1'b0;
        m_prev = 8'hFF; m_req = 1'b0; m_id = 0;
    endtask

    // Apply the controller rules for one clock edge using the inputs present at it.
    task automatic model_clock();
        logic [7:0]  edges, elig, below, pn, isv;
        logic [15:0] off;
        bit          wsel, acked;
        int          lvl;
        edges = irq_in & ~m_prev;
        lvl   = lowest(m_insv);
        below = 8'((1 << lvl) - 1);
        elig  = m_gie ? (m_pend & m_mask & below) : 8'h00;
        acked = m_req && int_ack;
        off   = bus_addr - BASE;
        wsel  = bus_we && (off < 16'd4);
        pn = m_pend;
        if (wsel && off == 16'd1) pn = pn & ~bus_wdata;
        if (acked) pn[m_id] = 1'b0;
        pn = pn | edges;
        isv = m_insv;
        if (int_ret && m_insv != 8'h00) isv[lvl] = 1'b0;
        if (acked) isv[m_id] = 1'b1;
        if (!m_req) begin
            if (elig != 8'h00) begin
                m_req = 1'b1;
                m_id  = lowest(elig);
            end
        end else if (acked || !elig[m_id]) begin
            m_req = 1'b0;
        end
        if (wsel && off == 16'd0) m_mask = bus_wdata;
        if (wsel && off == 16'd3) m_gie  = bus_wdata[0];
        m_pend = pn;
        m_insv = isv;
        m_prev = irq_in;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        reset = 1'b1; irq_in = 8'h00; bus_we = 1'b0; bus_addr = 16'h0000;
        bus_wdata = 8'h00; int_ack = 1'b0; int_ret = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (int_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", int_req); end
        n_checks++;
        if (int_vec !== 8'h00) begin n_fail++; $display("FAIL reset_vec: got %h want 00", int_vec); end
        for (int o = 0; o < 4; o++) begin
            rd(2'(o), d);
            n_checks++;
            if (d !== 8'h00) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 00", o, d); end
        end
        bus_addr = BASE + 16'd4;
        #1;
        n_checks++;
        if (bus_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_unmapped: got %h want 00", bus_rdata); end
    endtask

    task automatic test_basic();
        logic [7:0] d;
        wr(2'(0), 8'h04);
        wr(2'(3), 8'h01);
        irq_in[2] = 1'b1;
        tick();
        irq_in[2] = 1'b0;
        n_checks++;
        if (int_req !== 1'b0) begin n_fail++; $display("FAIL basic_latency1: got %b want 0", int_req); end
        tick();
        n_checks++;
        if (int_req !== 1'b1) begin n_fail++; $display("FAIL basic_req: got %b want 1", int_req); end
        n_checks++;
        if (int_vec !== 8'h18) begin n_fail++; $display("FAIL basic_vec: got %h want 18", int_vec); end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        n_checks++;
        if (int_req !== 1'b0) begin n_fail++; $display("FAIL basic_req_after_ack: got %b want 0", int_req); end
        rd(2'(1), d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL basic_pend: got %h want 00", d); end
        rd(2'(2), d);
        n_checks++;
        if (d !== 8'h04) begin n_fail++; $display("FAIL basic_insv: got %h want 04", d); end
    endtask

    task automatic test_nesting();
        logic [7:0] d;
        wr(2'(0), 8'hFF);
        irq_in = 8'h22;
        tick();
        irq_in = 8'h00;
        tick();
        n_checks++;
        if (int_req !== 1'b1 || int_vec !== 8'h14) begin
            n_fail++; $display("FAIL nest_src1: got req=%b vec=%h want req=1 vec=14", int_req, int_vec);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        rd(2'(2), d);
        n_checks++;
        if (d !== 8'h06) begin n_fail++; $display("FAIL nest_insv: got %h want 06", d); end
        rd(2'(1), d);
        n_checks++;
        if (d !== 8'h20) begin n_fail++; $display("FAIL nest_pend: got %h want 20", d); end
        tick(); tick();
        n_checks++;
        if (int_req !== 1'b0) begin n_fail++; $display("FAIL nest_src5_blocked: got %b want 0", int_req); end
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        rd(2'(2), d);
        n_checks++;
        if (d !== 8'h04) begin n_fail++; $display("FAIL nest_ret1_insv: got %h want 04", d); end
        tick(); tick();
        n_checks++;
        if (int_req !== 1'b0) begin n_fail++; $display("FAIL nest_src5_still_blocked: got %b want 0", int_req); end
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        tick();
        n_checks++;
        if (int_req !== 1'b1 || int_vec !== 8'h24) begin
            n_fail++; $display("FAIL nest_src5: got req=%b vec=%h want req=1 vec=24", int_req, int_vec);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        rd(2'(2), d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL nest_final_insv: got %h want 00", d); end
    endtask

    task automatic test_withdraw();
        logic [7:0] d;
        irq_in[3] = 1'b1;
        tick();
        irq_in[3] = 1'b0;
        tick();
        n_checks++;
        if (int_req !== 1'b1 || int_vec !== 8'h1C) begin
            n_fail++; $display("FAIL wd_req: got req=%b vec=%h want req=1 vec=1c", int_req, int_vec);
        end
        wr(2'(0), 8'hF7);
        n_checks++;
        if (int_req !== 1'b1) begin n_fail++; $display("FAIL wd_req_hold: got %b want 1", int_req); end
        tick();
        n_checks++;
        if (int_req !== 1'b0) begin n_fail++; $display("FAIL wd_drop: got %b want 0", int_req); end
        rd(2'(1), d);
        n_checks++;
        if (d !== 8'h08) begin n_fail++; $display("FAIL wd_pend_kept: got %h want 08", d); end
        wr(2'(0), 8'hFF);
        tick();
        n_checks++;
        if (int_req !== 1'b1 || int_vec !== 8'h1C) begin
            n_fail++; $display("FAIL wd_rereq: got req=%b vec=%h want req=1 vec=1c", int_req, int_vec);
        end
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
    endtask

    task automatic test_reset_edge();
        logic [7:0] d;
        irq_in = 8'h01;
        reset  = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        rd(2'(1), d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL edge_at_reset: got %h want 00", d); end
        irq_in = 8'h00;
        tick();
        irq_in = 8'h01;
        wr(2'(1), 8'h01);
        rd(2'(1), d);
        n_checks++;
        if (d !== 8'h01) begin n_fail++; $display("FAIL edge_beats_clear: got %h want 01", d); end
        irq_in = 8'h00;
        wr(2'(1), 8'h01);
        rd(2'(1), d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL w1c_pend: got %h want 00", d); end
    endtask

    task automatic test_ret_ack();
        logic [7:0] d;
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        rd(2'(2), d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL ret_idle_insv: got %h want 00", d); end
        wr(2'(0), 8'hFF);
        wr(2'(3), 8'h01);
        irq_in[3] = 1'b1;
        tick();
        irq_in[3] = 1'b0;
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        rd(2'(2), d);
        n_checks++;
        if (d !== 8'h08) begin n_fail++; $display("FAIL ra_insv_setup: got %h want 08", d); end
        irq_in[1] = 1'b1;
        tick();
        irq_in[1] = 1'b0;
        tick();
        n_checks++;
        if (int_req !== 1'b1 || int_vec !== 8'h14) begin
            n_fail++; $display("FAIL ra_req_src1: got req=%b vec=%h want req=1 vec=14", int_req, int_vec);
        end
        int_ack = 1'b1;
        int_ret = 1'b1;
        tick();
        int_ack = 1'b0;
        int_ret = 1'b0;
        rd(2'(2), d);
        n_checks++;
        if (d !== 8'h02) begin n_fail++; $display("FAIL ra_insv: got %h want 02", d); end
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        rd(2'(2), d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL ra_final_insv: got %h want 00", d); end
    endtask

    task automatic test_async_reset();
        logic [7:0] d;
        irq_in[4] = 1'b1;
        tick();
        irq_in[4] = 1'b0;
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        irq_in[2] = 1'b1;
        tick();
        irq_in[2] = 1'b0;
        tick();
        n_checks++;
        if (int_req !== 1'b1) begin n_fail++; $display("FAIL ar_setup_req: got %b want 1", int_req); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (int_req !== 1'b0 || int_vec !== 8'h00) begin
            n_fail++; $display("FAIL ar_outputs: got req=%b vec=%h want req=0 vec=00", int_req, int_vec);
        end
        rd(2'(0), d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL ar_mask: got %h want 00", d); end
        rd(2'(2), d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL ar_insv: got %h want 00", d); end
        rd(2'(3), d);
        n_checks++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL ar_ctrl: got %h want 00", d); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_random();
        irq_in = 8'h00; bus_we = 1'b0; int_ack = 1'b0; int_ret = 1'b0;
        reset = 1'b1;
        model_reset();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            n_checks++;
            if (int_req !== m_req) begin
                n_fail++; $display("FAIL rnd_req cyc %0d: got %b want %b", c, int_req, m_req);
            end
            if (m_req) begin
                n_checks++;
                if (int_vec !== 8'(16 + 4 * m_id)) begin
                    n_fail++; $display("FAIL rnd_vec cyc %0d: got %h want %h", c, int_vec, 8'(16 + 4 * m_id));
                end
            end
            for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
            int_ack   = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            int_ret   = ($urandom_range(0, 7) == 0);
            bus_we    = ($urandom_range(0, 5) == 0);
            bus_wdata = 8'($urandom);
            if ($urandom_range(0, 9) == 0) bus_addr = 16'($urandom);
            else bus_addr = BASE + 16'($urandom_range(0, 5));
            if (bus_we && bus_addr == BASE + 16'd3) bus_wdata[0] = ($urandom_range(0, 3) != 0);
            #1;
            n_checks++;
            if (bus_rdata !== model_read(bus_addr)) begin
                n_fail++; $display("FAIL rnd_rdata cyc %0d addr %h: got %h want %h", c, bus_addr, bus_rdata, model_read(bus_addr));
            end
            @(posedge clk);
            model_clock();
            #1;
        end
        bus_we = 1'b0; int_ack = 1'b0; int_ret = 1'b0; irq_in = 8'h00;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nesting();
        test_withdraw();
        test_reset_edge();
        test_ret_ack();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
